// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT stage sequencer.
package fft_pkg;

  localparam int FFT_LOG2N    = 10;
  localparam int FFT_PIPE_LAT = 4;
  localparam int FFT_N        = 1 << FFT_LOG2N;
  localparam int FFT_HALF_N   = FFT_N / 2;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } seq_state_t;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 DIT butterfly address generator: (stage, k) -> top/bottom leg
// addresses and twiddle ROM index. Purely combinational.
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  localparam int STAGE_W = $clog2(LOG2N)
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG2N-2:0]   k,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_addr
);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] tw_shift;

  // Split k into group and position within the group, then spread the
  // group index over blocks of 2*span; twiddle stride shrinks as span grows.
  always_comb begin
    k_ext    = {1'b0, k};
    span     = LOG2N'(1) << stage;
    pos      = k_ext & (span - LOG2N'(1));
    grp      = k_ext >> stage;
    addr_a   = ((grp << stage) << 1) | pos;
    addr_b   = addr_a + span;
    tw_shift = LOG2N'(LOG2N - 1) - LOG2N'(stage);
    tw_addr  = pos[LOG2N-2:0] << tw_shift;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage sequencer. Issues one butterfly read per
// cycle for N/2 cycles per stage, then idles PIPE_LAT cycles so the last
// write-back lands before the next stage reads. Write-back strobes and
// addresses are the read strobes/addresses delayed PIPE_LAT cycles.
// Optional macro FFT_SCALE_EN: scale = rd_en delayed one cycle (per-stage
// divide-by-2 request); otherwise scale is tied low.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N    = FFT_LOG2N,
  parameter int PIPE_LAT = FFT_PIPE_LAT,
  localparam int STAGE_W = $clog2(LOG2N)
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addrA,
  output logic [LOG2N-1:0]   rd_addrB,
  output logic [LOG2N-2:0]   tw_addr,
  output logic               wr_enA,
  output logic               wr_enB,
  output logic [LOG2N-1:0]   wr_addrA,
  output logic [LOG2N-1:0]   wr_addrB,
  output logic               scale
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1);

  seq_state_t         state_q, state_d;
  logic [LOG2N-2:0]   k_q;
  logic [STAGE_W-1:0] stage_q;
  logic [DRN_W-1:0]   drain_q;
  logic               k_last, drain_last, stage_last;

  logic [LOG2N-1:0]   gen_a, gen_b;
  logic [LOG2N-2:0]   gen_tw;

  logic               en_p     [PIPE_LAT];
  logic [LOG2N-1:0]   addr_a_p [PIPE_LAT];
  logic [LOG2N-1:0]   addr_b_p [PIPE_LAT];

  assign k_last     = &k_q;
  assign drain_last = (drain_q == DRN_W'(PIPE_LAT - 1));
  assign stage_last = (stage_q == STAGE_W'(LOG2N - 1));
  assign stage      = stage_q;

  fft_bfly_addr_gen #(
    .LOG2N(LOG2N)
  ) u_addr_gen (
    .stage  (stage_q),
    .k      (k_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_addr(gen_tw)
  );

  // Addresses are forced to zero whenever no read is issued.
  assign rd_addrA = rd_en ? gen_a  : '0;
  assign rd_addrB = rd_en ? gen_b  : '0;
  assign tw_addr  = rd_en ? gen_tw : '0;

  // FSM state register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (k_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_d = stage_last ? DONE : RUN;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly index, stage index and drain timer advance with the FSM;
  // outside RUN/DRAIN they park at zero so a new run starts at stage 0, k 0.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      k_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          k_q     <= k_last ? '0 : k_q + 1'b1;
          drain_q <= '0;
        end
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_last && !stage_last) stage_q <= stage_q + 1'b1;
        end
        default: begin
          k_q     <= '0;
          stage_q <= '0;
          drain_q <= '0;
        end
      endcase
    end
  end

  // Read-to-write delay line; clearing it on reset kills in-flight writes.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        en_p[i]     <= 1'b0;
        addr_a_p[i] <= '0;
        addr_b_p[i] <= '0;
      end
    end else begin
      en_p[0]     <= rd_en;
      addr_a_p[0] <= rd_addrA;
      addr_b_p[0] <= rd_addrB;
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_p[i]     <= en_p[i-1];
        addr_a_p[i] <= addr_a_p[i-1];
        addr_b_p[i] <= addr_b_p[i-1];
      end
    end
  end

  assign wr_enA   = en_p[PIPE_LAT-1];
  assign wr_enB   = en_p[PIPE_LAT-1];
  assign wr_addrA = addr_a_p[PIPE_LAT-1];
  assign wr_addrB = addr_b_p[PIPE_LAT-1];

`ifdef FFT_SCALE_EN
  // Scale request aligned with butterfly input data (one RAM read latency).
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) scale <= 1'b0;
    else       scale <= rd_en;
  end
`else
  assign scale = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: the stimulus side computes every
// expected read, write and done event from the FFT address rules and queues
// them; a negedge monitor pops and compares whatever the DUT presents.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int L     = FFT_LOG2N;
  localparam int PL    = FFT_PIPE_LAT;
  localparam int N     = FFT_N;
  localparam int HN    = FFT_HALF_N;
  localparam int SC    = HN + PL;
  localparam int TOTAL = L * SC;
  localparam int SW    = $clog2(L);

  logic          Clk, reset, start;
  logic          busy, done, rd_en, wr_enA, wr_enB, scale;
  logic [SW-1:0] stage;
  logic [L-1:0]  rd_addrA, rd_addrB, wr_addrA, wr_addrB;
  logic [L-2:0]  tw_addr;

  fft_stage_sequencer dut (
    .Clk(Clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .tw_addr(tw_addr), .wr_enA(wr_enA), .wr_enB(wr_enB),
    .wr_addrA(wr_addrA), .wr_addrB(wr_addrB), .scale(scale)
  );

  typedef struct { int t; int s; int a; int b; int tw; } rd_ev_t;
  typedef struct { int t; int a; int b; } wr_ev_t;

  rd_ev_t rd_q[$];
  wr_ev_t wr_q[$];
  int     done_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit run_active = 0;
  int exp_first = 0;
  int exp_done = 0;
  int wcount[N];
  bit prev_rd = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic longint pack_rd(int s, int a, int b, int tw);
    return (longint'(s) << 29) | (longint'(a) << 19) | (longint'(b) << 9) | longint'(tw);
  endfunction

  function automatic longint pack_wr(int ea, int eb, int a, int b);
    return (longint'(ea) << 21) | (longint'(eb) << 20) | (longint'(a) << 10) | longint'(b);
  endfunction

  function automatic longint outs();
    return longint'({busy, done, rd_en, wr_enA, wr_enB, scale, stage,
                     rd_addrA, rd_addrB, tw_addr, wr_addrA, wr_addrB});
  endfunction

  // Reference model: for each stage, walk the butterfly groups of width
  // 2*span in order; each group pairs x[base+p] with x[base+p+span] and uses
  // twiddle W_N^(p*N/(2*span)). Reads come back-to-back, each stage takes
  // N/2 + PL cycles, each write follows its read by PL cycles.
  task automatic model_push(input int first);
    for (int s = 0; s < L; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < HN / span; g++) begin
        for (int p = 0; p < span; p++) begin
          rd_ev_t r;
          wr_ev_t w;
          r.t  = first + s * SC + g * span + p;
          r.s  = s;
          r.a  = 2 * span * g + p;
          r.b  = r.a + span;
          r.tw = p * (HN / span);
          rd_q.push_back(r);
          w.t = r.t + PL;
          w.a = r.a;
          w.b = r.b;
          wr_q.push_back(w);
        end
      end
    end
    done_q.push_back(first + TOTAL);
  endtask

  task automatic begin_run(input int c0);
    foreach (wcount[i]) wcount[i] = 0;
    model_push(c0 + 1);
    exp_first  = c0 + 1;
    exp_done   = c0 + 1 + TOTAL;
    run_active = 1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic end_checks(input bit full);
    int bad;
    chk("pending_events", rd_q.size() + wr_q.size() + done_q.size(), 0);
    if (full) begin
      bad = 0;
      foreach (wcount[i]) if (wcount[i] != L) bad++;
      chk("write_coverage_bad_addrs", bad, 0);
    end
  endtask

  // hold=1 keeps start high through RUN, DRAIN and the done cycle;
  // hold=0 scatters random start pulses over the run.
  task automatic run_full(input bit hold);
    int c0;
    c0 = cyc;
    begin_run(c0);
    start = 1'b1;
    while (cyc < exp_done + 1) begin
      @(posedge Clk);
      #1;
      start = (cyc <= exp_done) && (hold || ($urandom_range(0, 7) == 0));
    end
    start = 1'b0;
    idle(8);
    end_checks(1);
  endtask

  task automatic run_abort();
    int c0, target;
    c0 = cyc;
    begin_run(c0);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    target = c0 + 1 + 3 * SC + int'($urandom_range(1, HN - 2));
    while (cyc < target) begin
      @(posedge Clk);
      #1;
    end
    @(negedge Clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_outputs_zero", outs(), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    run_active = 0;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b0;
    idle(12);
    end_checks(0);
  endtask

  // Monitor: compare every presented read/write/done against the queues,
  // plus busy and scale every cycle.
  always @(negedge Clk) begin : mon
    rd_ev_t r;
    wr_ev_t w;
    int     d;
    bit     eb, es;
    eb = run_active && (cyc >= exp_first) && (cyc < exp_done);
    chk("busy", busy, eb);
`ifdef FFT_SCALE_EN
    es = reset ? 1'b0 : prev_rd;
`else
    es = 1'b0;
`endif
    chk("scale", scale, es);
    prev_rd = reset ? 1'b0 : rd_en;

    if (rd_en) begin
      if (rd_q.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_time", cyc, r.t);
        chk("rd_stage_a_b_tw", pack_rd(int'(stage), int'(rd_addrA), int'(rd_addrB), int'(tw_addr)),
            pack_rd(r.s, r.a, r.b, r.tw));
      end
    end

    if (wr_enA || wr_enB) begin
      if (wr_enA) wcount[wr_addrA]++;
      if (wr_enB) wcount[wr_addrB]++;
      if (wr_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_time", cyc, w.t);
        chk("wr_en_addrs", pack_wr(int'(wr_enA), int'(wr_enB), int'(wr_addrA), int'(wr_addrB)),
            pack_wr(1, 1, w.a, w.b));
      end
    end

    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = done_q.pop_front();
        chk("done_time", cyc, d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs_zero", outs(), 0);
    reset = 1'b0;
    idle(5);
    run_full(1);
    idle($urandom_range(3, 10));
    run_full(0);
    idle($urandom_range(3, 10));
    run_abort();
    idle($urandom_range(3, 10));
    run_full(0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
